// File: rtl/core0_progmem.sv
// Program memory upstream of core0: byte-wide registered fetch, word-wide writes,
// and a boot-load FSM that holds core0 stopped until the initial image is streamed in.
module core0_progmem #(
    parameter int unsigned WORD_MAG           = 5,
    parameter int unsigned PROGRAM_ADDR_WIDTH = 8,
    localparam int unsigned WORD_WIDTH        = 1 << WORD_MAG,
    localparam int unsigned WADDR_WIDTH       = (PROGRAM_ADDR_WIDTH + 3) / 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] programmem_addr,
    output logic [7:0]                    programmem_read_value,
    input  logic [WADDR_WIDTH-1:0]        programmem_write_addr,
    input  logic [WORD_WIDTH-1:0]         programmem_write_value,
    input  logic                          programmem_we,
    input  logic [WORD_WIDTH-1:0]         boot_data,
    input  logic                          boot_valid,
    input  logic                          boot_last,
    output logic                          boot_ready,
    output logic                          core_run,
    output logic [WADDR_WIDTH-1:0]        load_count
);

    localparam int unsigned BYTES = WORD_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << PROGRAM_ADDR_WIDTH;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [WADDR_WIDTH-1:0]        load_count_q, load_count_d;
    logic                          boot_ready_q, boot_ready_d;
    logic                          core_run_q, core_run_d;
    logic [7:0]                    read_value_q, read_value_d;

    logic                          wr_en;
    logic [WADDR_WIDTH-1:0]        wr_waddr;
    logic [WORD_WIDTH-1:0]         wr_data;
    logic                          boot_accept;
    logic [PROGRAM_ADDR_WIDTH-1:0] lane_addr [BYTES];

    logic [7:0]                    mem_q [DEPTH];

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_LOAD;
            load_count_q <= '0;
            boot_ready_q <= 1'b0;
            core_run_q   <= 1'b0;
            read_value_q <= '0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            boot_ready_q <= boot_ready_d;
            core_run_q   <= core_run_d;
            read_value_q <= read_value_d;
        end
    end

    // Next-state, write-source selection and write-first read
    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        wr_en        = 1'b0;
        wr_waddr     = programmem_write_addr;
        wr_data      = programmem_write_value;
        boot_accept  = 1'b0;

        case (state_q)
            ST_LOAD: begin
                boot_accept = boot_valid && boot_ready_q;
                if (boot_accept) begin
                    wr_en    = 1'b1;
                    wr_waddr = load_count_q;
                    wr_data  = boot_data;
                    if (load_count_q != '1) begin
                        load_count_d = load_count_q + WADDR_WIDTH'(1);
                    end
                    if (boot_last || (load_count_q == '1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                wr_en = programmem_we;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        boot_ready_d = (state_d == ST_LOAD);
        core_run_d   = (state_d == ST_RUN);

        for (int i = 0; i < int'(BYTES); i++) begin
            lane_addr[i] = PROGRAM_ADDR_WIDTH'(32'(wr_waddr) * 32'(BYTES) + 32'(i));
        end

        // Ascending lane order lets the highest aliased lane win, matching the array write
        read_value_d = mem_q[programmem_addr];
        for (int i = 0; i < int'(BYTES); i++) begin
            if (wr_en && (lane_addr[i] == programmem_addr)) begin
                read_value_d = wr_data[8*i +: 8];
            end
        end
    end

    // Byte array; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(BYTES); i++) begin
                mem_q[lane_addr[i]] <= wr_data[8*i +: 8];
            end
        end
    end

    assign programmem_read_value = read_value_q;
    assign boot_ready            = boot_ready_q;
    assign core_run              = core_run_q;
    assign load_count            = load_count_q;

endmodule
